// File: rtl/interrupt_controller.sv
// Multi-thread interrupt controller: request synchronizer, edge/level capture,
// per-thread masking, lowest-index priority and a small register file.
module interrupt_controller #(
    parameter int NUM_INTERRUPTS   = 16,
    parameter int NUM_THREADS      = 4,
    parameter int THREAD_IDX_WIDTH = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int INT_ID_WIDTH     = (NUM_INTERRUPTS > 1) ? $clog2(NUM_INTERRUPTS) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_INTERRUPTS-1:0]                interrupt_req,
    input  logic                                     reg_write_en,
    input  logic                                     reg_read_en,
    input  logic [THREAD_IDX_WIDTH-1:0]              reg_thread_idx,
    input  logic [2:0]                               reg_index,
    input  logic [31:0]                              reg_write_val,
    output logic [31:0]                              reg_read_val,
    output logic [NUM_THREADS-1:0]                   ic_interrupt_pending,
    output logic [NUM_THREADS-1:0][INT_ID_WIDTH-1:0] ic_interrupt_id
);

    localparam logic [2:0] REG_MASK     = 3'd0;
    localparam logic [2:0] REG_TRIGGER  = 3'd1;
    localparam logic [2:0] REG_POLARITY = 3'd2;
    localparam logic [2:0] REG_ACK      = 3'd3;
    localparam logic [2:0] REG_PENDING  = 3'd4;
    localparam logic [2:0] REG_RAW      = 3'd5;
    localparam logic [2:0] REG_HIGHEST  = 3'd6;
    localparam logic [2:0] REG_RSVD     = 3'd7;

    logic [NUM_INTERRUPTS-1:0] s1, s2, eff, eff_prev, edge_det;
    logic [NUM_INTERRUPTS-1:0] trigger, polarity, wdata;
    logic [NUM_THREADS-1:0][NUM_INTERRUPTS-1:0] mask, latched;
    logic [NUM_THREADS-1:0][NUM_INTERRUPTS-1:0] ack_mask, pending, masked;
    logic [THREAD_IDX_WIDTH-1:0] tidx;
    logic [31:0] rdata;
    logic idx_ok, wr_ok;
    logic unused_wr_bits;

    assign unused_wr_bits = ^reg_write_val;
    assign wdata    = reg_write_val[NUM_INTERRUPTS-1:0];
    assign idx_ok   = 32'(reg_thread_idx) < 32'(NUM_THREADS);
    assign tidx     = idx_ok ? reg_thread_idx : '0;
    assign wr_ok    = reg_write_en && idx_ok;

    // A polarity write that raises eff is deliberately seen as an edge.
    assign eff      = s2 ^ polarity;
    assign edge_det = eff & ~eff_prev;

    always_comb begin
        ack_mask             = '0;
        pending              = '0;
        masked               = '0;
        ic_interrupt_pending = '0;
        ic_interrupt_id      = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (wr_ok && reg_index == REG_ACK &&
                tidx == THREAD_IDX_WIDTH'(t))
                ack_mask[t] = wdata;
            pending[t] = (trigger & eff) | (~trigger & latched[t]);
            masked[t]  = pending[t] & mask[t];
            ic_interrupt_pending[t] = |masked[t];
            for (int i = NUM_INTERRUPTS - 1; i >= 0; i--)
                if (masked[t][i])
                    ic_interrupt_id[t] = INT_ID_WIDTH'(i);
        end
    end

    always_comb begin
        rdata = '0;
        if (!idx_ok) begin
            rdata = '1;
        end else begin
            unique case (reg_index)
                REG_MASK:     rdata[NUM_INTERRUPTS-1:0] = mask[tidx];
                REG_TRIGGER:  rdata[NUM_INTERRUPTS-1:0] = trigger;
                REG_POLARITY: rdata[NUM_INTERRUPTS-1:0] = polarity;
                REG_ACK:      rdata = '0;
                REG_PENDING:  rdata[NUM_INTERRUPTS-1:0] = masked[tidx];
                REG_RAW:      rdata[NUM_INTERRUPTS-1:0] = s2;
                REG_HIGHEST: begin
                    rdata[31]                 = ic_interrupt_pending[tidx];
                    rdata[INT_ID_WIDTH-1:0]   = ic_interrupt_id[tidx];
                end
                REG_RSVD:     rdata = '1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1           <= '0;
            s2           <= '0;
            eff_prev     <= '0;
            latched      <= '0;
            mask         <= '0;
            trigger      <= '0;
            polarity     <= '0;
            reg_read_val <= '0;
        end else begin
            s1       <= interrupt_req;
            s2       <= s1;
            eff_prev <= eff;
            // New edges win over a same-cycle acknowledge.
            for (int t = 0; t < NUM_THREADS; t++)
                latched[t] <= (latched[t] & ~ack_mask[t]) | edge_det;
            if (wr_ok) begin
                if (reg_index == REG_MASK)
                    mask[tidx] <= wdata;
                if (reg_index == REG_TRIGGER)
                    trigger <= wdata;
                if (reg_index == REG_POLARITY)
                    polarity <= wdata;
            end
            if (reg_read_en)
                reg_read_val <= rdata;
        end
    end

    rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(reg_write_en && reg_read_en));

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: edge/level capture, priority,
// ack collisions, polarity and reset behaviour.
module tb_interrupt_controller;

    localparam logic [2:0] R_MASK = 3'd0;
    localparam logic [2:0] R_TRIG = 3'd1;
    localparam logic [2:0] R_POL  = 3'd2;
    localparam logic [2:0] R_ACK  = 3'd3;
    localparam logic [2:0] R_PEND = 3'd4;
    localparam logic [2:0] R_RAW  = 3'd5;
    localparam logic [2:0] R_HIGH = 3'd6;
    localparam logic [2:0] R_RSVD = 3'd7;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     interrupt_req;
    logic            reg_write_en;
    logic            reg_read_en;
    logic [1:0]      reg_thread_idx;
    logic [2:0]      reg_index;
    logic [31:0]     reg_write_val;
    logic [31:0]     reg_read_val;
    logic [3:0]      ic_interrupt_pending;
    logic [3:0][3:0] ic_interrupt_id;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] rv;

    interrupt_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .interrupt_req        (interrupt_req),
        .reg_write_en         (reg_write_en),
        .reg_read_en          (reg_read_en),
        .reg_thread_idx       (reg_thread_idx),
        .reg_index            (reg_index),
        .reg_write_val        (reg_write_val),
        .reg_read_val         (reg_read_val),
        .ic_interrupt_pending (ic_interrupt_pending),
        .ic_interrupt_id      (ic_interrupt_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [2:0] idx, input logic [1:0] thr,
                          input logic [31:0] val);
        reg_index      = idx;
        reg_thread_idx = thr;
        reg_write_val  = val;
        reg_write_en   = 1'b1;
        tick();
        reg_write_en   = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] idx, input logic [1:0] thr,
                          output logic [31:0] val);
        reg_index      = idx;
        reg_thread_idx = thr;
        reg_read_en    = 1'b1;
        tick();
        reg_read_en    = 1'b0;
        val            = reg_read_val;
    endtask

    task automatic chk_t0(input string tag, input logic pend,
                          input logic [3:0] id);
        check_eq({tag, "_pend"}, 32'(ic_interrupt_pending[0]), 32'(pend));
        check_eq({tag, "_id"}, 32'(ic_interrupt_id[0]), 32'(id));
    endtask

    initial begin
        reset          = 1'b1;
        interrupt_req  = '0;
        reg_write_en   = 1'b0;
        reg_read_en    = 1'b0;
        reg_thread_idx = '0;
        reg_index      = '0;
        reg_write_val  = '0;
        tick();
        tick();
        check_eq("rst_pend", 32'(ic_interrupt_pending), 32'h0);
        check_eq("rst_id", 32'(ic_interrupt_id), 32'h0);
        check_eq("rst_rdval", reg_read_val, 32'h0);
        reset = 1'b0;
        tick();

        // edge mode on line 2, thread 0
        reg_wr(R_MASK, 2'd0, 32'h4);
        interrupt_req[2] = 1'b1;
        tick();
        chk_t0("edge_k", 1'b0, 4'd0);
        tick();
        chk_t0("edge_k1", 1'b0, 4'd0);
        tick();
        chk_t0("edge_k2", 1'b1, 4'd2);
        check_eq("edge_t1_masked", 32'(ic_interrupt_pending[1]), 32'h0);
        reg_wr(R_ACK, 2'd0, 32'h4);
        chk_t0("edge_ack", 1'b0, 4'd0);
        interrupt_req[2] = 1'b0;
        tick();
        tick();

        // level mode on line 0, thread 1
        reg_wr(R_TRIG, 2'd0, 32'h1);
        reg_wr(R_MASK, 2'd1, 32'h1);
        interrupt_req[0] = 1'b1;
        tick();
        check_eq("lvl_k", 32'(ic_interrupt_pending[1]), 32'h0);
        tick();
        check_eq("lvl_k1", 32'(ic_interrupt_pending[1]), 32'h1);
        tick();
        tick();
        reg_wr(R_ACK, 2'd1, 32'h1);
        check_eq("lvl_ack", 32'(ic_interrupt_pending[1]), 32'h1);
        interrupt_req[0] = 1'b0;
        tick();
        check_eq("lvl_fall_k", 32'(ic_interrupt_pending[1]), 32'h1);
        tick();
        check_eq("lvl_fall_k1", 32'(ic_interrupt_pending[1]), 32'h0);
        reg_wr(R_TRIG, 2'd0, 32'h0);
        check_eq("lvl_to_edge", 32'(ic_interrupt_pending[1]), 32'h0);

        // priority between lines 3 and 9
        reg_wr(R_ACK, 2'd0, 32'hffff);
        reg_wr(R_MASK, 2'd0, 32'hffff);
        chk_t0("pri_clear", 1'b0, 4'd0);
        interrupt_req[3] = 1'b1;
        interrupt_req[9] = 1'b1;
        tick();
        tick();
        tick();
        chk_t0("pri_both", 1'b1, 4'd3);
        reg_rd(R_HIGH, 2'd0, rv);
        check_eq("pri_highest", rv, 32'h8000_0003);
        reg_rd(R_PEND, 2'd0, rv);
        check_eq("pri_pending", rv, 32'h0000_0208);
        reg_rd(R_RAW, 2'd0, rv);
        check_eq("pri_raw", rv, 32'h0000_0208);
        reg_rd(R_ACK, 2'd0, rv);
        check_eq("ack_reads_0", rv, 32'h0);
        reg_wr(R_ACK, 2'd0, 32'h8);
        chk_t0("pri_ack3", 1'b1, 4'd9);
        reg_wr(R_ACK, 2'd0, 32'h200);
        chk_t0("pri_ack9", 1'b0, 4'd0);
        interrupt_req[3] = 1'b0;
        interrupt_req[9] = 1'b0;

        // ack and new edge on line 5 in the same cycle
        interrupt_req[5] = 1'b1;
        tick();
        tick();
        reg_wr(R_ACK, 2'd0, 32'h20);
        chk_t0("coll_keep", 1'b1, 4'd5);
        reg_wr(R_ACK, 2'd0, 32'h20);
        chk_t0("coll_clear", 1'b0, 4'd0);
        interrupt_req[5] = 1'b0;

        // falling edge capture with polarity on line 1
        interrupt_req[1] = 1'b1;
        tick();
        tick();
        tick();
        reg_wr(R_POL, 2'd0, 32'h2);
        reg_wr(R_ACK, 2'd0, 32'h2);
        chk_t0("pol_quiet", 1'b0, 4'd0);
        interrupt_req[1] = 1'b0;
        tick();
        tick();
        chk_t0("pol_fall_k1", 1'b0, 4'd0);
        tick();
        chk_t0("pol_fall_k2", 1'b1, 4'd1);
        reg_wr(R_ACK, 2'd0, 32'h2);
        chk_t0("pol_ack", 1'b0, 4'd0);

        // polarity write raising eff on line 4
        reg_wr(R_POL, 2'd0, 32'h12);
        chk_t0("pol_spur_k", 1'b0, 4'd0);
        tick();
        chk_t0("pol_spur_k1", 1'b1, 4'd4);
        reg_rd(R_POL, 2'd0, rv);
        check_eq("pol_read", rv, 32'h12);
        reg_wr(R_ACK, 2'd0, 32'h10);

        // unimplemented upper bits
        reg_wr(R_MASK, 2'd3, 32'hffff_ffff);
        reg_rd(R_MASK, 2'd3, rv);
        check_eq("mask_width", rv, 32'h0000_ffff);

        // reset in the middle of activity
        interrupt_req[7] = 1'b1;
        tick();
        tick();
        tick();
        chk_t0("pre_rst", 1'b1, 4'd7);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_pend", 32'(ic_interrupt_pending), 32'h0);
        check_eq("mid_rst_id", 32'(ic_interrupt_id), 32'h0);
        check_eq("mid_rst_rdval", reg_read_val, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        reg_rd(R_MASK, 2'd0, rv);
        check_eq("post_rst_mask", rv, 32'h0);
        reg_rd(R_RSVD, 2'd0, rv);
        check_eq("rsvd_read", rv, 32'hffff_ffff);
        tick();
        check_eq("rdval_hold", reg_read_val, 32'hffff_ffff);
        reg_wr(R_MASK, 2'd0, 32'h80);
        chk_t0("held_edge", 1'b1, 4'd7);
        reg_wr(R_ACK, 2'd0, 32'h80);
        tick();
        tick();
        chk_t0("held_once", 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_INTERRUPTS, default 16, range 1..32: number of interrupt request lines.
REQ-002 SHALL have parameter NUM_THREADS, default 4, range 1..16: number of hardware threads served.
REQ-003 SHALL have parameter THREAD_IDX_WIDTH, default $clog2(NUM_THREADS) (minimum 1): thread index width.
REQ-004 SHALL have parameter INT_ID_WIDTH, default $clog2(NUM_INTERRUPTS) (minimum 1): interrupt ID width.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port interrupt_req, input, NUM_INTERRUPTS bits: asynchronous request lines.
REQ-008 SHALL have port reg_write_en, input, 1 bit: register write strobe.
REQ-009 SHALL have port reg_read_en, input, 1 bit: register read strobe.
REQ-010 SHALL have port reg_thread_idx, input, THREAD_IDX_WIDTH bits: thread targeted by per-thread registers.
REQ-011 SHALL have port reg_index, input, 3 bits: register select.
REQ-012 SHALL have port reg_write_val, input, 32 bits: write data.
REQ-013 SHALL have port reg_read_val, output, 32 bits: registered read data.
REQ-014 SHALL have port ic_interrupt_pending, output, NUM_THREADS bits: per-thread "any enabled interrupt pending".
REQ-015 SHALL have port ic_interrupt_id, output, NUM_THREADS x INT_ID_WIDTH: per-thread highest-priority pending ID.

Function
REQ-016 SHALL pass interrupt_req through a two-flop synchronizer (s1, s2) per line; s2 is the only level used downstream.
REQ-017 SHALL form effective level eff = s2 XOR polarity, where polarity bit 1 = active-low / falling edge.
REQ-018 SHALL register eff_prev each cycle; edge = eff AND NOT eff_prev; a polarity write causing a 0->1 change of eff SHALL be treated as an edge.
REQ-019 SHALL hold a per-thread latched register: latched_next = (latched AND NOT ack_mask) OR edge, where a new edge wins over a simultaneous ack.
REQ-020 SHALL compute raw pending per thread as (trigger AND eff) OR (NOT trigger AND latched[t]), where trigger bit 1 = level.
REQ-021 SHALL assert ic_interrupt_pending[t] = OR(pending[t] AND mask[t]), combinationally from registered state.
REQ-022 SHALL drive ic_interrupt_id[t] = lowest set bit index of (pending[t] AND mask[t]), with lowest index = highest priority; value is 0 when none.
REQ-023 SHALL use this register map (reg_index): 0 MASK (per-thread, RW); 1 TRIGGER (global, RW); 2 POLARITY (global, RW); 3 ACK (per-thread, W, clears latched bits set in write data); 4 PENDING (per-thread, R, masked); 5 RAW (R, s2); 6 HIGHEST (per-thread, R, {31'b0 pending flag at bit 31... no: bit 31 = ic_interrupt_pending[t], low bits = ID}); 7 reserved.
REQ-024 SHALL ignore bits at and above NUM_INTERRUPTS on writes, and SHALL read them as 0.
REQ-025 SHALL ignore writes to read-only or reserved indices; reads of index 7 SHALL return 32'hffffffff.
REQ-026 SHALL update reg_read_val on the edge following reg_read_en, with 1-cycle latency, and SHALL hold it otherwise.
REQ-027 SHALL make a register write visible to outputs and reads from the next cycle.
REQ-028 SHALL give level-mode lines pending visibility after edge k+1 when req is first sampled high at edge k, and edge-mode lines after edge k+2.
REQ-029 SHALL treat simultaneous reg_write_en and reg_read_en as illegal (simulation assertion).
REQ-030 SHALL ignore reg_thread_idx values >= NUM_THREADS for writes; reads SHALL return 32'hffffffff.

Reset
REQ-031 SHALL, on reset, clear s1, s2, eff_prev, latched, mask, trigger, polarity and reg_read_val to 0 immediately and asynchronously, forcing ic_interrupt_pending = 0 and ic_interrupt_id = 0.
REQ-032 SHALL discard in-flight edges when reset is asserted mid-operation; a line held high through reset deassertion (polarity 0) SHALL produce one edge.

Verification
REQ-033 Edge mode: mask[0] = 0x4, req[2] 0->1 at edge k -> ic_interrupt_pending[0] = 1 and ic_interrupt_id[0] = 2 after edge k+2; ACK 0x4 -> pending clears next cycle.
REQ-034 Level mode: TRIGGER = 0x1, mask[1] = 0x1, req[0] high for 5 cycles then low -> pending[1] follows with 2-cycle lag; ACK has no effect.
REQ-035 Priority: lines 3 and 9 both latched with mask 0xFFFF -> ID = 3; ACK 0x8 -> ID = 9.
REQ-036 Ack/edge collision: ACK bit 5 written in the same cycle a new edge on line 5 is latched -> bit 5 remains pending.
REQ-037 Polarity: POLARITY = 0x2, req[1] 1->0 -> edge latched; a write of POLARITY that flips eff 0->1 -> spurious edge latched.
REQ-038 Reset mid-operation: reset asserted with pending bits -> all outputs 0 same cycle; MASK reads 0 after release; reserved index read -> 0xffffffff.
